// File: rtl/f_pc_sequencer.sv
// ============================================================================
// Module   : f_pc_sequencer
// Brief    : Fetch-stage PC owner. Sequences boot, sequential/branch advance,
//            hazard hold, exception entry and eret return, and generates the
//            fetch-valid qualifier and the one-cycle F/D wrong-path flush.
//            Optional macro FETCH_ADEL_EN enables the fetch address-error
//            detector (alignment and text-segment bounds on PC_F).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module f_pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180,
    parameter logic [31:0] TEXT_LO  = 32'h0000_3000,
    parameter logic [31:0] TEXT_HI  = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_F,
    input  logic        Req,
    input  logic        eret_D,
    input  logic [31:0] EPCOut,
    input  logic [31:0] NPC,
    output logic [31:0] PC_F,
    output logic        fetch_valid,
    output logic        flush_FD,
    output logic        adel_F,
    output logic [1:0]  state_dbg
);

    // Encoded state values double as the debug port encoding.
    typedef enum logic [1:0] {
        c_BOOT  = 2'd0,
        c_RUN   = 2'd1,
        c_STALL = 2'd2,
        c_FLUSH = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] w_next_pc;

    // State and PC registers; reset overrides every other input on its edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_BOOT;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
        end
    end

    // Next-state / next-PC selection. BOOT is a single dead cycle; every other
    // state applies the redirect priority Req > eret (unstalled) > stall > NPC.
    // A stalled eret is deliberately ignored: the eret is still sitting in D
    // and will be seen again once the stall releases.
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        if (r_state == c_BOOT) begin
            w_next_state = c_RUN;
            w_next_pc    = r_pc;
        end else if (Req) begin
            w_next_state = c_FLUSH;
            w_next_pc    = EXC_PC;
        end else if (eret_D && !stall_F) begin
            w_next_state = c_FLUSH;
            w_next_pc    = EPCOut;
        end else if (stall_F) begin
            w_next_state = c_STALL;
            w_next_pc    = r_pc;
        end else begin
            w_next_state = c_RUN;
            w_next_pc    = NPC;
        end
    end

    // Outputs are pure decodes of registered state, so none of them has a
    // combinational path from the inputs.
    always_comb begin
        PC_F        = r_pc;
        state_dbg   = r_state;
        fetch_valid = (r_state != c_BOOT);
        flush_FD    = (r_state == c_FLUSH);
    end

`ifdef FETCH_ADEL_EN
    logic w_misaligned;
    logic w_below_text;
    logic w_above_text;

    // Address-error detect on the current fetch address; sequencing is not
    // affected, CP0 answers by raising Req.
    always_comb begin
        w_misaligned = (r_pc[1:0] != 2'b00);
        w_below_text = (r_pc < TEXT_LO);
        w_above_text = (r_pc > TEXT_HI);
        adel_F       = fetch_valid && (w_misaligned || w_below_text || w_above_text);
    end
`else
    // Detector not built: no address error is ever reported.
    always_comb begin
        adel_F = 1'b0;
    end
`endif

endmodule

`default_nettype wire
